ecc_mem_responder: RTL and testbench

ECC_MEM_RESPONDER -- requirements
Module: ecc_mem_responder

---
 rtl/ecc_mem_responder.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ecc_mem_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ecc_mem_responder.sv
// ecc_mem_responder: SEC-DED (39,32) protected word memory behind a valid/ready port.
// Define ECC_SCRUB_EN to write back corrected codewords on single-error reads.
module ecc_mem_responder #(
    parameter int DEPTH = 256,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    input  logic [38:0]      err_inj,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             busy_init,
    output logic             ecc_sec,
    output logic             ecc_ded,
    output logic             addr_err,
    output logic [CNT_W-1:0] sec_count,
    output logic [CNT_W-1:0] ded_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        READ,
        CHECK,
        WRITE,
        RESP
    } state_t;

    function automatic logic [38:0] ecc_enc(input logic [31:0] d);
        logic [38:0] c;
        int j;
        c = '0;
        j = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                c[6'(p)] = d[5'(j)];
                j++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            for (int p = 1; p < 39; p++) begin
                if (p[5'(k)] && p != (1 << k)) begin
                    c[6'(1 << k)] = c[6'(1 << k)] ^ c[6'(p)];
                end
            end
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic logic [31:0] ecc_dat(input logic [38:0] c);
        logic [31:0] d;
        int j;
        d = '0;
        j = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[5'(j)] = c[6'(p)];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [5:0] ecc_syn(input logic [38:0] c);
        logic [5:0] s;
        s = '0;
        for (int p = 1; p < 39; p++) begin
            if (c[6'(p)]) begin
                s = s ^ 6'(p);
            end
        end
        return s;
    endfunction

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic             oor_q, oor_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;
    logic             ready_q, ready_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             sec_q, sec_d;
    logic             ded_q, ded_d;
    logic             aerr_q, aerr_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

    logic [38:0]      mem_q [DEPTH];
    logic [38:0]      cw_q;

    logic             we;
    logic             re;
    logic [AW-1:0]    waddr;
    logic [38:0]      wcw;

    logic [5:0]       syn;
    logic             par_bad;
    logic             dbl;
    logic             sgl;
    logic             scrub;
    logic [38:0]      fix;
    logic [31:0]      data_c;
    logic [31:0]      merged;

    logic             unused_ok;
    assign unused_ok = ^{mem_instr, mem_addr[1:0]};

    // Decode runs on the registered codeword, stable from CHECK through RESP.
    always_comb begin
        syn     = ecc_syn(cw_q);
        par_bad = ^cw_q;
        dbl     = (syn != 6'd0 && !par_bad) || syn > 6'd38;
        sgl     = par_bad && !dbl;
        fix     = sgl ? (39'd1 << syn) : '0;
        data_c  = ecc_dat(cw_q ^ fix);
        merged  = {
            wstrb_q[3] ? wdata_q[31:24] : data_c[31:24],
            wstrb_q[2] ? wdata_q[23:16] : data_c[23:16],
            wstrb_q[1] ? wdata_q[15:8]  : data_c[15:8],
            wstrb_q[0] ? wdata_q[7:0]   : data_c[7:0]
        };
    end

`ifdef ECC_SCRUB_EN
    assign scrub = sgl;
`else
    assign scrub = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        oor_d     = oor_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        sec_d     = 1'b0;
        ded_d     = 1'b0;
        aerr_d    = 1'b0;
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        we        = 1'b0;
        re        = 1'b0;
        waddr     = addr_q;
        wcw       = ecc_enc(merged) ^ err_inj;
        unique case (state_q)
            INIT: begin
                we    = !reset;
                waddr = idx_q;
                wcw   = ecc_enc(32'h0) ^ err_inj;
                if (idx_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            IDLE: begin
                // ready_q still high means the previous response is on the bus
                if (mem_valid && !ready_q) begin
                    addr_d  = mem_addr[AW+1:2];
                    oor_d   = mem_addr[31:2] >= 30'(DEPTH);
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    state_d = READ;
                end
            end
            READ: begin
                re      = !oor_q;
                state_d = CHECK;
            end
            CHECK: begin
                if (!oor_q && (wstrb_q != 4'h0 || scrub)) begin
                    state_d = WRITE;
                end else begin
                    state_d = RESP;
                end
            end
            WRITE: begin
                we      = !reset;
                state_d = RESP;
            end
            RESP: begin
                ready_d = 1'b1;
                rdata_d = oor_q ? 32'h0 : data_c;
                sec_d   = !oor_q && sgl;
                ded_d   = !oor_q && dbl;
                aerr_d  = oor_q;
                if (sec_d && sec_cnt_q != '1) begin
                    sec_cnt_d = sec_cnt_q + CNT_W'(1);
                end
                if (ded_d && ded_cnt_q != '1) begin
                    ded_cnt_d = ded_cnt_q + CNT_W'(1);
                end
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= INIT;
            idx_q     <= '0;
            addr_q    <= '0;
            oor_q     <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            ready_q   <= 1'b0;
            rdata_q   <= '0;
            sec_q     <= 1'b0;
            ded_q     <= 1'b0;
            aerr_q    <= 1'b0;
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            oor_q     <= oor_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            ready_q   <= ready_d;
            rdata_q   <= rdata_d;
            sec_q     <= sec_d;
            ded_q     <= ded_d;
            aerr_q    <= aerr_d;
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wcw;
        end
        if (re) begin
            cw_q <= mem_q[addr_q];
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign busy_init = (state_q == INIT);
    assign ecc_sec   = sec_q;
    assign ecc_ded   = ded_q;
    assign addr_err  = aerr_q;
    assign sec_count = sec_cnt_q;
    assign ded_count = ded_cnt_q;

endmodule

// File: tb/tb_ecc_mem_responder.sv
// Scoreboard bench for ecc_mem_responder: data/error-mask reference model,
// directed corner cases, randomized traffic and a mid-transaction reset.
module tb_ecc_mem_responder;

    localparam int DEPTH = 256;
    localparam int CNT_W = 16;
`ifdef ECC_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             mem_valid = 1'b0;
    logic             mem_instr = 1'b0;
    logic [31:0]      mem_addr = '0;
    logic [31:0]      mem_wdata = '0;
    logic [3:0]       mem_wstrb = '0;
    logic [38:0]      err_inj = '0;
    logic             mem_ready;
    logic [31:0]      mem_rdata;
    logic             busy_init;
    logic             ecc_sec;
    logic             ecc_ded;
    logic             addr_err;
    logic [CNT_W-1:0] sec_count;
    logic [CNT_W-1:0] ded_count;

    ecc_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .err_inj(err_inj),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .busy_init(busy_init), .ecc_sec(ecc_sec),
        .ecc_ded(ecc_ded), .addr_err(addr_err),
        .sec_count(sec_count), .ded_count(ded_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        bit          sec;
        bit          ded;
        bit          aerr;
        int          sec_cnt;
        int          ded_cnt;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;
    logic [31:0] last_rdata;

    // Reference: each word is its data plus the flip mask it was stored with.
    logic [31:0] m_data [DEPTH];
    logic [38:0] m_mask [DEPTH];
    int m_sec = 0;
    int m_ded = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] flip_of(input logic [38:0] m);
        logic [31:0] f;
        int j;
        f = '0;
        j = 0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                f[5'(j)] = m[6'(p)];
                j++;
            end
        end
        return f;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_mask[i] = '0;
        end
        m_sec = 0;
        m_ded = 0;
    endtask

    task automatic model_req(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [38:0] inj,
                             output exp_t e);
        int idx;
        int n;
        logic [31:0] base;
        logic [31:0] bm;
        idx = int'(a[31:2]);
        e.sec = 0;
        e.ded = 0;
        e.aerr = 0;
        e.lat = 3;
        if (idx >= DEPTH) begin
            e.rdata = '0;
            e.aerr = 1;
        end else begin
            n = $countones(m_mask[idx]);
            e.sec = (n == 1);
            e.ded = (n == 2);
            base = e.ded ? (m_data[idx] ^ flip_of(m_mask[idx])) : m_data[idx];
            e.rdata = base;
            if (e.sec && m_sec < (1 << CNT_W) - 1) m_sec++;
            if (e.ded && m_ded < (1 << CNT_W) - 1) m_ded++;
            if (s != 4'h0) begin
                bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                m_data[idx] = (base & ~bm) | (d & bm);
                m_mask[idx] = inj;
                e.lat = 4;
            end else if (SCRUB && e.sec) begin
                m_data[idx] = base;
                m_mask[idx] = inj;
                e.lat = 4;
            end
        end
        e.sec_cnt = m_sec;
        e.ded_cnt = m_ded;
        e.acc = 0;
    endtask

    // Leaves mem_valid high after the response so the next call checks that
    // a held request is not re-accepted while mem_ready is still up.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [38:0] inj);
        exp_t e;
        bit got;
        @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_addr = a;
        mem_wdata = d;
        mem_wstrb = s;
        err_inj = inj;
        mem_instr = 1'($urandom);
        @(posedge clk);
        #1;
        model_req(a, d, s, inj, e);
        e.acc = cyc;
        sbq.push_back(e);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (mem_ready) begin
                got = 1;
                last_rdata = mem_rdata;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL req_timeout: no mem_ready for addr %0h", a);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_ready", 64'(mem_ready), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_busy", 64'(busy_init), 64'd1);
        chk("rst_flags", 64'({ecc_sec, ecc_ded, addr_err}), 64'd0);
        chk("rst_cnts", 64'({sec_count, ded_count}), 64'd0);
    endtask

    // Called #1 after the edge that follows reset release.
    task automatic init_sweep();
        int n;
        n = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            @(negedge clk);
            if (busy_init) n++;
            else break;
        end
        chk("busy_cycles", 64'(n), 64'(DEPTH));
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && mem_ready) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: rdata %0h at cycle %0d",
                         mem_rdata, cyc);
            end else begin
                e = sbq.pop_front();
                chk("rdata", 64'(mem_rdata), 64'(e.rdata));
                chk("ecc_sec", 64'(ecc_sec), 64'(e.sec));
                chk("ecc_ded", 64'(ecc_ded), 64'(e.ded));
                chk("addr_err", 64'(addr_err), 64'(e.aerr));
                chk("sec_count", 64'(sec_count), 64'(e.sec_cnt));
                chk("ded_count", 64'(ded_count), 64'(e.ded_cnt));
                chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
        end else if (!reset) begin
            chk("idle_flags", 64'({ecc_sec, ecc_ded, addr_err}), 64'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [38:0] inj;
        int r;
        int b1;
        int b2;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals();
        reset = 1'b0;
        init_sweep();

        do_req(32'h000, 32'h0, 4'h0, '0);
        chk("read0", 64'(last_rdata), 64'h0);

        do_req(32'h010, 32'hDEADBEEF, 4'hF, '0);
        do_req(32'h010, 32'h0, 4'h0, '0);
        chk("deadbeef", 64'(last_rdata), 64'hDEADBEEF);

        do_req(32'h020, 32'h12345678, 4'hF, 39'd1 << 5);
        do_req(32'h020, 32'h0, 4'h0, '0);
        do_req(32'h020, 32'h0, 4'h0, '0);
        chk("sec_read", 64'(last_rdata), 64'h12345678);
        chk("sec_cnt_dir", 64'(sec_count), SCRUB ? 64'd1 : 64'd2);

        do_req(32'h030, 32'hCAFEF00D, 4'hF, (39'd1 << 3) | (39'd1 << 9));
        do_req(32'h030, 32'h0, 4'h0, '0);
        chk("ded_read", 64'(last_rdata), 64'hCAFEF01C);
        chk("ded_cnt_dir", 64'(ded_count), 64'd1);

        do_req(32'h040, 32'hAABBCCDD, 4'hF, '0);
        do_req(32'h040, 32'h00110000, 4'h4, '0);
        do_req(32'h040, 32'h0, 4'h0, '0);
        chk("merge", 64'(last_rdata), 64'hAA11CCDD);

        do_req(32'h400, 32'h0, 4'h0, '0);
        chk("oor_read", 64'(last_rdata), 64'h0);
        do_req(32'h400, 32'h55555555, 4'hF, '0);
        do_req(32'h000, 32'h0, 4'h0, '0);
        chk("oor_no_alias", 64'(last_rdata), 64'h0);

        for (int t = 0; t < 80; t++) begin
            r = $urandom_range(15, 0);
            if (r == 15) a = $urandom | 32'h0000_0400;
            else a = 32'($urandom_range(7, 0) * 4 + $urandom_range(3, 0));
            r = $urandom_range(9, 0);
            b1 = $urandom_range(38, 0);
            b2 = (b1 + $urandom_range(38, 1)) % 39;
            if (r < 7) inj = '0;
            else if (r < 9) inj = 39'd1 << b1;
            else inj = (39'd1 << b1) | (39'd1 << b2);
            do_req(a, $urandom, ($urandom_range(1, 0) == 1) ?
                   4'($urandom) : 4'h0, inj);
        end

        do_req(32'h050, 32'h11111111, 4'hF, '0);
        @(posedge clk);
        #1;
        mem_addr = 32'h050;
        mem_wdata = 32'h22222222;
        mem_wstrb = 4'hF;
        err_inj = '0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_valid = 1'b0;
        #1;
        chk_reset_vals();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_ready", 64'(mem_ready), 64'd0);
        end
        model_clear();
        reset = 1'b0;
        init_sweep();
        do_req(32'h050, 32'h0, 4'h0, '0);
        chk("after_reinit", 64'(last_rdata), 64'h0);

        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
